// File: rtl/req_initiator.sv
// Requester side of a single-wire req/resp handshake: issues one request per start,
// counts grants against the responder budget and latches a sticky error.
module req_initiator #(
    parameter int unsigned MAX_RESP = 3,
    parameter int unsigned TIMEOUT  = 2,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             resp,
    output logic             req,
    output logic             _rt_get,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt,
    output logic             exhausted,
    output logic             drop,
    output logic             error
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic             req_n, busy_n, exhausted_n, drop_n, error_n;
    logic [CNT_W-1:0] grant_cnt_n;

    assign _rt_get = req;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            req       <= 1'b0;
            busy      <= 1'b0;
            grant_cnt <= '0;
            exhausted <= 1'b0;
            drop      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            req       <= req_n;
            busy      <= busy_n;
            grant_cnt <= grant_cnt_n;
            exhausted <= exhausted_n;
            drop      <= drop_n;
            error     <= error_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        req_n       = req;
        busy_n      = busy;
        grant_cnt_n = grant_cnt;
        exhausted_n = exhausted;
        drop_n      = 1'b0;
        error_n     = error;

        unique case (state)
            IDLE: begin
                req_n  = 1'b0;
                busy_n = 1'b0;
                // A resp with nothing outstanding is a protocol violation
                if (resp) begin
                    error_n = 1'b1;
                    state_n = LOCK;
                end else if (start && !exhausted) begin
                    req_n   = 1'b1;
                    busy_n  = 1'b1;
                    timer_n = '0;
                    state_n = REQ;
                end else if (start) begin
                    drop_n = 1'b1;
                end
            end
            REQ: begin
                drop_n = start;
                if (resp) begin
                    if (grant_cnt != CNT_W'(MAX_RESP))
                        grant_cnt_n = grant_cnt + CNT_W'(1);
                    exhausted_n = (grant_cnt_n == CNT_W'(MAX_RESP));
                    req_n       = 1'b0;
                    busy_n      = 1'b0;
                    state_n     = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    error_n = 1'b1;
                    req_n   = 1'b0;
                    busy_n  = 1'b0;
                    state_n = LOCK;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            LOCK: begin
                req_n   = 1'b0;
                busy_n  = 1'b0;
                error_n = 1'b1;
                drop_n  = start;
            end
            default: begin
                state_n = LOCK;
                req_n   = 1'b0;
                busy_n  = 1'b0;
                error_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_req_initiator.sv
// Directed bench for req_initiator: per-cycle expectations are queued when stimulus
// is applied and popped against the outputs one edge later.
module tb_req_initiator;

    logic       clk = 1'b0;
    logic       reset, start, resp;
    logic       req, rt_get, busy, exhausted, drop, error;
    logic [2:0] grant_cnt;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string      tag;
        logic       req;
        logic       busy;
        logic [2:0] cnt;
        logic       exh;
        logic       drop;
        logic       err;
    } exp_t;

    exp_t sb[$];

    req_initiator #(.MAX_RESP(3), .TIMEOUT(2), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .resp      (resp),
        .req       (req),
        ._rt_get   (rt_get),
        .busy      (busy),
        .grant_cnt (grant_cnt),
        .exhausted (exhausted),
        .drop      (drop),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    endtask

    // Apply one cycle of stimulus and check the outputs registered at that edge
    task automatic cyc(input logic r, input logic s, input logic p, input string tag,
                       input logic e_req, input logic e_busy, input logic [2:0] e_cnt,
                       input logic e_exh, input logic e_drop, input logic e_err);
        exp_t e;
        reset = r;
        start = s;
        resp  = p;
        sb.push_back('{tag, e_req, e_busy, e_cnt, e_exh, e_drop, e_err});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "req",       8'(req),       8'(e.req));
        chk(e.tag, "rt_get",    8'(rt_get),    8'(e.req));
        chk(e.tag, "busy",      8'(busy),      8'(e.busy));
        chk(e.tag, "grant_cnt", 8'(grant_cnt), 8'(e.cnt));
        chk(e.tag, "exhausted", 8'(exhausted), 8'(e.exh));
        if (!$isunknown(e.drop))
            chk(e.tag, "drop",  8'(drop),      8'(e.drop));
        chk(e.tag, "error",     8'(error),     8'(e.err));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        resp  = 1'b0;
        @(posedge clk);
        #1;

        // 1: single grant with resp two cycles after start
        cyc(1, 0, 0, "t1_rst", 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 1, 0, "t1_c0",  1, 1, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, "t1_c1",  1, 1, 3'd0, 0, 0, 0);
        cyc(0, 0, 1, "t1_c2",  0, 0, 3'd1, 0, 0, 0);
        cyc(0, 0, 0, "t1_c3",  0, 0, 3'd1, 0, 0, 0);

        // 2: exhaust the grant budget, then a start is dropped
        cyc(0, 1, 0, "t2_s2",  1, 1, 3'd1, 0, 0, 0);
        cyc(0, 0, 1, "t2_g2",  0, 0, 3'd2, 0, 0, 0);
        cyc(0, 0, 0, "t2_i2",  0, 0, 3'd2, 0, 0, 0);
        cyc(0, 1, 0, "t2_s3",  1, 1, 3'd2, 0, 0, 0);
        cyc(0, 0, 1, "t2_g3",  0, 0, 3'd3, 1, 0, 0);
        cyc(0, 0, 0, "t2_i3",  0, 0, 3'd3, 1, 0, 0);
        cyc(0, 1, 0, "t2_s4",  0, 0, 3'd3, 1, 1, 0);
        cyc(0, 0, 0, "t2_i4",  0, 0, 3'd3, 1, 0, 0);

        // 3: timeout locks with a sticky error
        cyc(1, 0, 0, "t3_rst", 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 1, 0, "t3_s",   1, 1, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, "t3_w1",  1, 1, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, "t3_to",  0, 0, 3'd0, 0, 0, 1);
        cyc(0, 1, 0, "t3_drp", 0, 0, 3'd0, 0, 1, 1);
        cyc(0, 0, 0, "t3_hld", 0, 0, 3'd0, 0, 0, 1);

        // 4: spurious resp beats a same-cycle start; LOCK ignores resp
        cyc(1, 0, 0, "t4_rst", 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 1, 1, "t4_sp",  0, 0, 3'd0, 0, 1'bx, 1);
        cyc(0, 1, 0, "t4_drp", 0, 0, 3'd0, 0, 1, 1);
        cyc(0, 0, 1, "t4_ign", 0, 0, 3'd0, 0, 0, 1);

        // 5: reset mid-request clears everything, then normal operation
        cyc(1, 0, 0, "t5_rst", 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 1, 0, "t5_s",   1, 1, 3'd0, 0, 0, 0);
        cyc(1, 1, 1, "t5_mid", 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 1, 0, "t5_s2",  1, 1, 3'd0, 0, 0, 0);
        cyc(0, 0, 1, "t5_g",   0, 0, 3'd1, 0, 0, 0);

        // 6: start pulses during REQ each drop, only one grant counted
        cyc(1, 0, 0, "t6_rst", 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 1, 0, "t6_s",   1, 1, 3'd0, 0, 0, 0);
        cyc(0, 1, 0, "t6_d1",  1, 1, 3'd0, 0, 1, 0);
        cyc(0, 1, 1, "t6_d2",  0, 0, 3'd1, 0, 1, 0);
        cyc(0, 0, 0, "t6_end", 0, 0, 3'd1, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
